ina_adc_sequencer: RTL and testbench
====================================

# ina_adc_sequencer

- Models the INA219 conversion engine that sits directly upstream of the register-file model.
- Samples raw shunt and bus ADC codes and applies the configured resolution and averaging.
- Sequences shunt-then-bus conversions in triggered or continuous mode.
- Publishes the averaged shunt value, the formatted bus-voltage word (CNVR/OVF flags included) and status; these feed the shunt and voltage inputs of the register-file model.

## Interface
- CYCLES_PER_SAMPLE, 8, clock cycles per single ADC sample (≥2)
- clock  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- raw_shunt  in  16  signed shunt sample, 10 µV/LSB
- raw_bus  in  13  unsigned bus sample, 4 mV/LSB
- mode  in  3  config_reg[2:0] operating mode
- sadc  in  4  config_reg[6:3] shunt ADC setting
- badc  in  4  config_reg[10:7] bus ADC setting
- pga  in  2  config_reg[12:11] PGA gain
- cfg_wr  in  1  one-cycle pulse: configuration register written
- cnvr_clr  in  1  one-cycle pulse: power register read (clears CNVR)
- shunt_out  out  16  averaged signed shunt result
- bus_out  out  16  {bus[12:0], 1'b0, CNVR, OVF}
- busy  out  1  conversion in progress

## Operation
- States: IDLE, SHUNT, BUS. All outputs reset to 0; state resets to IDLE.
- Modes:
  - 0 (power-down) and 4 (ADC off): stay in or return to IDLE.
  - 1/2/3 (triggered: shunt / bus / both): one pass per cfg_wr.
  - 5/6/7 (continuous: shunt / bus / both): repeat passes indefinitely.
  - The pass begins in SHUNT when the mode includes shunt, otherwise in BUS.
- After reset, continuous modes start immediately; triggered modes wait for cfg_wr.
- ADC setting decode, 4-bit field s:
  - s[3]=0: one sample at 9+s[1:0] bits; the low 12-(9+s[1:0]) bits of the sample are cleared.
  - s[3]=1: 12-bit samples, N = 1<<s[2:0] (1 to 128).
- Sampling and averaging:
  - Each sample takes CYCLES_PER_SAMPLE cycles; raw input is captured on the last cycle of each sample slot.
  - Accumulator widths: 23-bit signed for shunt, 20-bit unsigned for bus.
  - Result = accumulator >>> log2(N); arithmetic shift for shunt, floor toward −∞.
- Phase completion:
  - SHUNT completes: update shunt_out; go to BUS when the mode includes bus, else end pass.
  - BUS completes: update bus_out[15:3]; end pass.
- OVF: set at shunt completion if |avg| > limit for pga. Limits are 0→4000, 1→8000, 2→16000, 3→32000. Cleared otherwise.
- CNVR:
  - Set on the cycle the pass ends.
  - Cleared on cnvr_clr or cfg_wr.
  - A set in the same cycle as cnvr_clr wins.
- End of pass: continuous modes restart at the first phase the next cycle; triggered modes go to IDLE.
- cfg_wr at any time:
  - Aborts the current pass and zeroes accumulators and counters.
  - Leaves shunt_out and bus_out[15:3] unchanged.
  - Restarts the new mode's first phase the next cycle (IDLE for mode 0 or 4).
- busy = state != IDLE.
- Inputs mode, sadc, badc and pga are sampled only on cfg_wr or at reset.

## Timing
- cfg_wr in cycle t → busy=1 in cycle t+1.
- Shunt-only pass, Ns samples: shunt_out and CNVR update at t+1+Ns·C.
- Shunt+bus pass: bus_out updates and CNVR rises at t+1+(Ns+Nb)·C.
- C = CYCLES_PER_SAMPLE.
- Continuous mode: a new pass starts with no idle cycle between passes.
- Reset mid-conversion: takes effect next edge, all outputs 0.

## Structure
- Package ina_pkg:
  - mode encodings;
  - state enum;
  - PGA limit constants 4000/8000/16000/32000;
  - function decoding an ADC setting into sample count log2 and resolution mask.
- One sub-module, ina_adc_avg: sample-slot counter, accumulator and shift. Instantiated twice, shunt (signed, 16-bit) and bus (unsigned, 13-bit), with a start/done handshake to the sequencer FSM.

## Test plan
- Reset, mode=3, sadc=badc=8, C=8; raw_shunt=1234, raw_bus=3000; cfg_wr at t → shunt_out=1234 at t+9, bus_out=(3000<<3)|2 at t+17, busy falls.
- sadc=0xB (8 samples), raw_shunt alternating −100/−101 → shunt_out=−101 (floor of −100.5). CNVR then cleared by cnvr_clr.
- sadc=0 (9-bit), raw_shunt=0x0FFF → shunt_out=0x0FF8; raw_shunt=−1 → −8.
- pga=0, raw_shunt=4001 → OVF=1; raw_shunt=−4000 → OVF=0. pga=3, raw_shunt=30000 → OVF=0.
- Mode 7 continuous: CNVR re-sets every 16 cycles. cfg_wr mid-BUS → pass restarts, bus_out unchanged, CNVR cleared.
- cnvr_clr coincident with pass end → CNVR=1. Mode 0 after cfg_wr → busy stays 0 and outputs hold.

Source files
------------

// File: rtl/ina_pkg.sv
// ---------------------------------------------------------------------------
// ina_pkg
// Shared definitions for the INA219 conversion-engine model:
//   - operating-mode encodings (config_reg[2:0])
//   - sequencer state enum
//   - PGA full-scale limits used for the shunt overflow flag
//   - ADC-setting decode into averaging count (log2) and resolution mask
// ---------------------------------------------------------------------------
package ina_pkg;

   // Operating modes. Bit 0 selects shunt, bit 1 selects bus, bit 2 continuous.
   localparam logic [2:0] MODE_POWER_DOWN = 3'd0;
   localparam logic [2:0] MODE_TRIG_SHUNT = 3'd1;
   localparam logic [2:0] MODE_TRIG_BUS   = 3'd2;
   localparam logic [2:0] MODE_TRIG_BOTH  = 3'd3;
   localparam logic [2:0] MODE_ADC_OFF    = 3'd4;
   localparam logic [2:0] MODE_CONT_SHUNT = 3'd5;
   localparam logic [2:0] MODE_CONT_BUS   = 3'd6;
   localparam logic [2:0] MODE_CONT_BOTH  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHUNT = 2'd1,
      ST_BUS   = 2'd2
   } state_t;

   // Shunt overflow limits in 10 uV LSBs for PGA gain /1, /2, /4, /8.
   localparam logic [15:0] PGA_LIMIT_0 = 16'd4000;
   localparam logic [15:0] PGA_LIMIT_1 = 16'd8000;
   localparam logic [15:0] PGA_LIMIT_2 = 16'd16000;
   localparam logic [15:0] PGA_LIMIT_3 = 16'd32000;

   typedef struct packed {
      logic [2:0]  log2n;  // averaging count is 1 << log2n
      logic [15:0] mask;   // clears LSBs below the selected resolution
   } adc_setting_t;

   // Low nibble codes 0..3 select a single 9..12 bit sample; codes with
   // bit 3 set select 12-bit samples averaged over 1..128 conversions.
   function automatic adc_setting_t adc_decode(input logic [3:0] s);
      adc_setting_t r;
      if (s[3]) begin
         r.log2n = s[2:0];
         r.mask  = 16'hFFFF;
      end else begin
         r.log2n = 3'd0;
         r.mask  = 16'hFFFF << (2'd3 - s[1:0]);
      end
      return r;
   endfunction

   function automatic logic [15:0] pga_limit(input logic [1:0] pga);
      logic [15:0] lim;
      case (pga)
         2'd0:    lim = PGA_LIMIT_0;
         2'd1:    lim = PGA_LIMIT_1;
         2'd2:    lim = PGA_LIMIT_2;
         default: lim = PGA_LIMIT_3;
      endcase
      return lim;
   endfunction

   // First phase of a pass for a given mode; IDLE when no ADC is enabled.
   function automatic state_t first_phase(input logic [2:0] m);
      state_t st;
      if (m[0])      st = ST_SHUNT;
      else if (m[1]) st = ST_BUS;
      else           st = ST_IDLE;
      return st;
   endfunction

endpackage

// File: rtl/ina_adc_avg.sv
// ---------------------------------------------------------------------------
// ina_adc_avg
// One ADC channel: counts sample slots, accumulates the captured samples and
// produces the floor average once the configured number of samples is in.
//   clock, rst  : clock and synchronous active-high reset
//   clr         : abort; zeroes counters and accumulator
//   start       : held high while the sequencer is in this channel's phase
//   log2n       : averaging count as a power of two
//   sample      : pre-masked raw sample
//   done        : high in the last cycle of the last sample slot
//   result      : average including the sample captured in that cycle
// ---------------------------------------------------------------------------
module ina_adc_avg #(
   parameter int W      = 16,
   parameter int ACC_W  = 23,
   parameter bit SIGNED = 1'b1,
   parameter int CYCLES = 8
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         clr,
   input  logic         start,
   input  logic [2:0]   log2n,
   input  logic [W-1:0] sample,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CW-1:0]    cyc_q, cyc_d;
   logic [6:0]       cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] samp_ext;
   logic [ACC_W-1:0] acc_sum;
   logic [6:0]       last_idx;
   logic             slot_end;

   assign slot_end = start && (cyc_q == CW'(CYCLES - 1));
   assign last_idx = 7'((8'd1 << log2n) - 8'd1);
   assign acc_sum  = acc_q + samp_ext;
   assign done     = slot_end && (cnt_q == last_idx);

   // The result is formed combinationally from the final sum so the caller
   // can register it on the same edge that captures the last sample.
   generate
      if (SIGNED) begin : g_signed
         assign samp_ext = {{(ACC_W - W){sample[W-1]}}, sample};
         assign result   = W'($signed(acc_sum) >>> log2n);
      end else begin : g_unsigned
         assign samp_ext = {{(ACC_W - W){1'b0}}, sample};
         assign result   = W'(acc_sum >> log2n);
      end
   endgenerate

   always_comb begin
      cyc_d = cyc_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (clr || !start) begin
         cyc_d = '0;
         cnt_d = '0;
         acc_d = '0;
      end else if (slot_end) begin
         cyc_d = '0;
         if (done) begin
            // Ready for an immediate restart in continuous mode.
            cnt_d = '0;
            acc_d = '0;
         end else begin
            cnt_d = cnt_q + 7'd1;
            acc_d = acc_sum;
         end
      end else begin
         cyc_d = cyc_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         cyc_q <= '0;
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/ina_adc_sequencer.sv
// ---------------------------------------------------------------------------
// ina_adc_sequencer
// INA219 conversion engine: sequences shunt-then-bus conversions in
// triggered or continuous mode and publishes the averaged results.
//   clock, rst        : clock and synchronous active-high reset
//   raw_shunt/raw_bus : raw ADC samples (signed 10 uV / unsigned 4 mV LSB)
//   mode/sadc/badc/pga: configuration fields, latched on cfg_wr or reset
//   cfg_wr            : configuration written; aborts and restarts a pass
//   cnvr_clr          : power register read; clears CNVR
//   shunt_out         : averaged shunt result
//   bus_out           : {bus[12:0], 0, CNVR, OVF}
//   busy              : a conversion pass is in progress
// ---------------------------------------------------------------------------
module ina_adc_sequencer
   import ina_pkg::*;
#(
   parameter int CYCLES_PER_SAMPLE = 8
) (
   input  logic        clock,
   input  logic        rst,
   input  logic [15:0] raw_shunt,
   input  logic [12:0] raw_bus,
   input  logic [2:0]  mode,
   input  logic [3:0]  sadc,
   input  logic [3:0]  badc,
   input  logic [1:0]  pga,
   input  logic        cfg_wr,
   input  logic        cnvr_clr,
   output logic [15:0] shunt_out,
   output logic [15:0] bus_out,
   output logic        busy
);

   state_t      state_q, state_d;
   logic [2:0]  mode_q, mode_d;
   logic [3:0]  sadc_q, sadc_d;
   logic [3:0]  badc_q, badc_d;
   logic [1:0]  pga_q, pga_d;
   logic [15:0] shunt_q, shunt_d;
   logic [12:0] bus_q, bus_d;
   logic        cnvr_q, cnvr_d;
   logic        ovf_q, ovf_d;

   adc_setting_t scfg, bcfg;
   logic [15:0]  shunt_samp;
   logic [12:0]  bus_samp;
   logic         shunt_done, bus_done;
   logic [15:0]  shunt_avg;
   logic [12:0]  bus_avg;
   logic [16:0]  shunt_ext, shunt_abs;
   logic         pass_end;

   assign scfg       = adc_decode(sadc_q);
   assign bcfg       = adc_decode(badc_q);
   assign shunt_samp = raw_shunt & scfg.mask;
   assign bus_samp   = 13'({3'b000, raw_bus} & bcfg.mask);

   ina_adc_avg #(
      .W      (16),
      .ACC_W  (23),
      .SIGNED (1'b1),
      .CYCLES (CYCLES_PER_SAMPLE)
   ) u_shunt_avg (
      .clock  (clock),
      .rst    (rst),
      .clr    (cfg_wr),
      .start  (state_q == ST_SHUNT),
      .log2n  (scfg.log2n),
      .sample (shunt_samp),
      .done   (shunt_done),
      .result (shunt_avg)
   );

   ina_adc_avg #(
      .W      (13),
      .ACC_W  (20),
      .SIGNED (1'b0),
      .CYCLES (CYCLES_PER_SAMPLE)
   ) u_bus_avg (
      .clock  (clock),
      .rst    (rst),
      .clr    (cfg_wr),
      .start  (state_q == ST_BUS),
      .log2n  (bcfg.log2n),
      .sample (bus_samp),
      .done   (bus_done),
      .result (bus_avg)
   );

   // 17 bits so that |-32768| is representable.
   assign shunt_ext = {shunt_avg[15], shunt_avg};
   assign shunt_abs = shunt_ext[16] ? (~shunt_ext + 17'd1) : shunt_ext;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      sadc_d   = sadc_q;
      badc_d   = badc_q;
      pga_d    = pga_q;
      shunt_d  = shunt_q;
      bus_d    = bus_q;
      ovf_d    = ovf_q;
      cnvr_d   = cnvr_q;
      pass_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Only reachable with a continuous mode latched straight after reset.
            if (mode_q[2]) state_d = first_phase(mode_q);
         end
         ST_SHUNT: begin
            if (shunt_done) begin
               shunt_d = shunt_avg;
               ovf_d   = shunt_abs > {1'b0, pga_limit(pga_q)};
               if (mode_q[1]) state_d = ST_BUS;
               else           pass_end = 1'b1;
            end
         end
         ST_BUS: begin
            if (bus_done) begin
               bus_d    = bus_avg;
               pass_end = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pass_end) state_d = mode_q[2] ? first_phase(mode_q) : ST_IDLE;

      // A completing pass sets CNVR even if it is being cleared this cycle.
      if (cnvr_clr) cnvr_d = 1'b0;
      if (pass_end) cnvr_d = 1'b1;

      // A configuration write discards any result completing this cycle.
      if (cfg_wr) begin
         mode_d  = mode;
         sadc_d  = sadc;
         badc_d  = badc;
         pga_d   = pga;
         state_d = first_phase(mode);
         shunt_d = shunt_q;
         bus_d   = bus_q;
         ovf_d   = ovf_q;
         cnvr_d  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= mode;
         sadc_q  <= sadc;
         badc_q  <= badc;
         pga_q   <= pga;
         shunt_q <= '0;
         bus_q   <= '0;
         cnvr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         sadc_q  <= sadc_d;
         badc_q  <= badc_d;
         pga_q   <= pga_d;
         shunt_q <= shunt_d;
         bus_q   <= bus_d;
         cnvr_q  <= cnvr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign shunt_out = shunt_q;
   assign bus_out   = {bus_q, 1'b0, cnvr_q, ovf_q};
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ina_adc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ina_adc_sequencer
// Directed checks of the INA219 conversion engine with C = 8.
// Cycle t is the cycle in which cfg_wr is high; write_cfg returns in t+1.
// ---------------------------------------------------------------------------
module tb_ina_adc_sequencer;

   logic        clock = 1'b0;
   logic        rst;
   logic [15:0] raw_shunt;
   logic [12:0] raw_bus;
   logic [2:0]  mode;
   logic [3:0]  sadc;
   logic [3:0]  badc;
   logic [1:0]  pga;
   logic        cfg_wr;
   logic        cnvr_clr;
   logic [15:0] shunt_out;
   logic [15:0] bus_out;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   ina_adc_sequencer #(.CYCLES_PER_SAMPLE(8)) dut (
      .clock     (clock),
      .rst       (rst),
      .raw_shunt (raw_shunt),
      .raw_bus   (raw_bus),
      .mode      (mode),
      .sadc      (sadc),
      .badc      (badc),
      .pga       (pga),
      .cfg_wr    (cfg_wr),
      .cnvr_clr  (cnvr_clr),
      .shunt_out (shunt_out),
      .bus_out   (bus_out),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write_cfg(input logic [2:0] m, input logic [3:0] s,
                            input logic [3:0] b, input logic [1:0] p);
      mode   = m;
      sadc   = s;
      badc   = b;
      pga    = p;
      cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick_n(3);
      n_checks++;
      if (shunt_out !== 16'h0000) begin n_fail++; $display("FAIL reset_shunt: got %h expected 0000", shunt_out); end
      n_checks++;
      if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL reset_bus: got %h expected 0000", bus_out); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      tick_n(3);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 0", busy); end
      $display("test_reset done");
   endtask

   task automatic test_both_pass();
      raw_shunt = 16'd1234;
      raw_bus   = 13'd3000;
      write_cfg(3'd3, 4'd8, 4'd8, 2'd0);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_t1: got %b expected 1", busy); end
      tick_n(7);
      n_checks++;
      if (shunt_out !== 16'h0000) begin n_fail++; $display("FAIL shunt_t8: got %h expected 0000", shunt_out); end
      tick();
      n_checks++;
      if (shunt_out !== 16'd1234) begin n_fail++; $display("FAIL shunt_t9: got %0d expected 1234", shunt_out); end
      tick_n(7);
      n_checks++;
      if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL bus_t16: got %h expected 0000", bus_out); end
      tick();
      n_checks++;
      if (bus_out !== 16'h5DC2) begin n_fail++; $display("FAIL bus_t17: got %h expected 5dc2", bus_out); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_t17: got %b expected 0", busy); end
      $display("test_both_pass done");
   endtask

   task automatic test_average();
      write_cfg(3'd1, 4'hB, 4'd8, 2'd0);
      for (int k = 0; k < 8; k++) begin
         raw_shunt = (k % 2 == 0) ? -16'sd100 : -16'sd101;
         if (k == 7) begin
            tick_n(7);
            n_checks++;
            if (shunt_out !== 16'd1234) begin n_fail++; $display("FAIL avg_t64: got %h expected 04d2", shunt_out); end
            tick();
         end else begin
            tick_n(8);
         end
      end
      n_checks++;
      if (shunt_out !== 16'hFF9B) begin n_fail++; $display("FAIL avg_floor: got %h expected ff9b", shunt_out); end
      n_checks++;
      if (bus_out !== 16'h5DC2) begin n_fail++; $display("FAIL avg_bus_cnvr: got %h expected 5dc2", bus_out); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL avg_busy: got %b expected 0", busy); end
      cnvr_clr = 1'b1;
      tick();
      cnvr_clr = 1'b0;
      n_checks++;
      if (bus_out !== 16'h5DC0) begin n_fail++; $display("FAIL avg_cnvr_clr: got %h expected 5dc0", bus_out); end
      $display("test_average done");
   endtask

   task automatic test_resolution();
      logic [15:0] raws [3]   = '{16'h0FFF, 16'hFFFF, 16'h0FFF};
      logic [3:0]  sets [3]   = '{4'd0, 4'd0, 4'd2};
      logic [15:0] expect_v [3] = '{16'h0FF8, 16'hFFF8, 16'h0FFE};
      for (int i = 0; i < 3; i++) begin
         raw_shunt = raws[i];
         write_cfg(3'd1, sets[i], 4'd8, 2'd0);
         tick_n(8);
         n_checks++;
         if (shunt_out !== expect_v[i]) begin
            n_fail++;
            $display("FAIL resolution_%0d: got %h expected %h", i, shunt_out, expect_v[i]);
         end
      end
      $display("test_resolution done");
   endtask

   task automatic test_ovf();
      logic [15:0] raws [5]  = '{16'd4001, 16'hF060, 16'd30000, 16'hE0BF, 16'd16001};
      logic [1:0]  gains [5] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd2};
      logic        ovf_e [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         raw_shunt = raws[i];
         write_cfg(3'd1, 4'd8, 4'd8, gains[i]);
         tick_n(8);
         n_checks++;
         if (bus_out[0] !== ovf_e[i]) begin
            n_fail++;
            $display("FAIL ovf_%0d: got %b expected %b", i, bus_out[0], ovf_e[i]);
         end
      end
      $display("test_ovf done");
   endtask

   task automatic test_continuous();
      raw_shunt = 16'd500;
      raw_bus   = 13'd100;
      write_cfg(3'd7, 4'd8, 4'd8, 2'd0);
      tick_n(15);
      n_checks++;
      if (bus_out !== 16'h5DC0) begin n_fail++; $display("FAIL cont_t16: got %h expected 5dc0", bus_out); end
      tick();
      n_checks++;
      if (bus_out !== 16'h0322) begin n_fail++; $display("FAIL cont_t17: got %h expected 0322", bus_out); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy: got %b expected 1", busy); end
      n_checks++;
      if (shunt_out !== 16'd500) begin n_fail++; $display("FAIL cont_shunt: got %0d expected 500", shunt_out); end
      cnvr_clr = 1'b1;
      tick();
      cnvr_clr = 1'b0;
      n_checks++;
      if (bus_out[1] !== 1'b0) begin n_fail++; $display("FAIL cont_clr: got %b expected 0", bus_out[1]); end
      tick_n(14);
      n_checks++;
      if (bus_out[1] !== 1'b0) begin n_fail++; $display("FAIL cont_t32: got %b expected 0", bus_out[1]); end
      tick();
      n_checks++;
      if (bus_out[1] !== 1'b1) begin n_fail++; $display("FAIL cont_t33: got %b expected 1", bus_out[1]); end
      // Abort in the middle of the next BUS phase (cycle t+44).
      tick_n(11);
      raw_bus = 13'd200;
      write_cfg(3'd7, 4'd8, 4'd8, 2'd0);
      n_checks++;
      if (bus_out !== 16'h0320) begin n_fail++; $display("FAIL abort_u1: got %h expected 0320", bus_out); end
      tick_n(15);
      n_checks++;
      if (bus_out !== 16'h0320) begin n_fail++; $display("FAIL abort_u16: got %h expected 0320", bus_out); end
      tick();
      n_checks++;
      if (bus_out !== 16'h0642) begin n_fail++; $display("FAIL abort_u17: got %h expected 0642", bus_out); end
      $display("test_continuous done");
   endtask

   task automatic test_clr_coincident();
      // Entered at u+17 of the continuous pass train.
      cnvr_clr = 1'b1;
      tick();
      cnvr_clr = 1'b0;
      n_checks++;
      if (bus_out[1] !== 1'b0) begin n_fail++; $display("FAIL coin_pre: got %b expected 0", bus_out[1]); end
      tick_n(14);
      cnvr_clr = 1'b1;
      tick();
      cnvr_clr = 1'b0;
      n_checks++;
      if (bus_out[1] !== 1'b1) begin n_fail++; $display("FAIL coin_set_wins: got %b expected 1", bus_out[1]); end
      $display("test_clr_coincident done");
   endtask

   task automatic test_power_down();
      write_cfg(3'd0, 4'd8, 4'd8, 2'd0);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL pd_busy_t1: got %b expected 0", busy); end
      tick_n(20);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL pd_busy_t21: got %b expected 0", busy); end
      n_checks++;
      if (shunt_out !== 16'd500) begin n_fail++; $display("FAIL pd_shunt: got %0d expected 500", shunt_out); end
      n_checks++;
      if (bus_out !== 16'h0640) begin n_fail++; $display("FAIL pd_bus: got %h expected 0640", bus_out); end
      write_cfg(3'd4, 4'd8, 4'd8, 2'd0);
      tick_n(10);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL adc_off_busy: got %b expected 0", busy); end
      $display("test_power_down done");
   endtask

   task automatic test_reset_mid();
      raw_shunt = 16'd777;
      write_cfg(3'd7, 4'd8, 4'd8, 2'd0);
      tick_n(4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (shunt_out !== 16'h0000) begin n_fail++; $display("FAIL rmid_shunt: got %h expected 0000", shunt_out); end
      n_checks++;
      if (bus_out !== 16'h0000) begin n_fail++; $display("FAIL rmid_bus: got %h expected 0000", bus_out); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_autostart: got %b expected 1", busy); end
      tick_n(7);
      n_checks++;
      if (shunt_out !== 16'h0000) begin n_fail++; $display("FAIL rmid_early: got %h expected 0000", shunt_out); end
      tick();
      n_checks++;
      if (shunt_out !== 16'd777) begin n_fail++; $display("FAIL rmid_shunt_done: got %0d expected 777", shunt_out); end
      $display("test_reset_mid done");
   endtask

   initial begin
      rst       = 1'b1;
      raw_shunt = '0;
      raw_bus   = '0;
      mode      = 3'd0;
      sadc      = 4'd0;
      badc      = 4'd0;
      pga       = 2'd0;
      cfg_wr    = 1'b0;
      cnvr_clr  = 1'b0;
      test_reset();
      test_both_pass();
      test_average();
      test_resolution();
      test_ovf();
      test_continuous();
      test_clr_coincident();
      test_power_down();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
